// File: rtl/matvec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : matvec_pkg                                                   |
// | Description : Shared types and elaboration-time helpers for the fp16       |
// |               matrix-vector multiplier (issue FSM state, result tag,       |
// |               reduction-tree depth and end-to-end latency).                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package matvec_pkg;

    localparam int FP16_W = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Travels beside each issued row so the datapath itself needs no reset.
    typedef struct packed {
        logic       valid;
        logic [1:0] row;
        logic       last;
    } tag_t;

    // Depth of a balanced binary adder tree over n leaves.
    function automatic int clog2_tree(input int n);
        int d;
        d = 0;
        for (int s = 1; s < n; s = s * 2) begin
            d++;
        end
        return d;
    endfunction

    // Accept edge to result edge for row 0: capture, issue register,
    // multiplier, adder tree, output register.
    function automatic int matvec_latency(input int n, input int mul_lat, input int add_lat);
        return 2 + mul_lat + add_lat * clog2_tree(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_half.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_half                                                     |
// | Description : fp16 adder, round-to-nearest-even, LAT-cycle latency.        |
// |               Subnormals flush to zero; exact cancellation gives +0.       |
// | Ports       : clk, a[15:0], b[15:0] in; y[15:0] out (a+b, LAT cycles later)|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module add_half #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    logic [15:0]       w_big;
    logic [15:0]       w_sml;
    logic [4:0]        w_dexp;
    logic [13:0]       w_sig_big;
    logic [13:0]       w_sig_sml;
    logic [13:0]       w_sig_sh;
    logic [13:0]       w_lost_mask;
    logic [14:0]       w_sum;
    logic [3:0]        w_pos;
    logic [3:0]        w_shl;
    logic [13:0]       w_norm;
    logic signed [7:0] w_exp;
    logic              w_rup;
    logic [10:0]       w_rnd;
    logic [15:0]       w_y;

    always_comb begin
        if (a[14:0] >= b[14:0]) begin
            w_big = a;
            w_sml = b;
        end else begin
            w_big = b;
            w_sml = a;
        end
        // 11-bit significand plus guard/round/sticky positions.
        w_sig_big   = (w_big[14:10] == 5'd0) ? 14'd0 : {1'b1, w_big[9:0], 3'b000};
        w_sig_sml   = (w_sml[14:10] == 5'd0) ? 14'd0 : {1'b1, w_sml[9:0], 3'b000};
        w_dexp      = w_big[14:10] - w_sml[14:10];
        w_lost_mask = ~(14'h3FFF << w_dexp);
        if (w_dexp >= 5'd14) begin
            w_sig_sh = {13'd0, |w_sig_sml};
        end else begin
            w_sig_sh = (w_sig_sml >> w_dexp) | {13'd0, |(w_sig_sml & w_lost_mask)};
        end
        if (w_big[15] ^ w_sml[15]) begin
            w_sum = {1'b0, w_sig_big} - {1'b0, w_sig_sh};
        end else begin
            w_sum = {1'b0, w_sig_big} + {1'b0, w_sig_sh};
        end
        w_exp = $signed({3'b000, w_big[14:10]});
        w_pos = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (w_sum[i]) begin
                w_pos = 4'(i);
            end
        end
        w_shl = 4'd13 - w_pos;
        if (w_sum[14]) begin
            w_norm = w_sum[14:1] | {13'd0, w_sum[0]};
            w_exp  = w_exp + 8'sd1;
        end else begin
            w_norm = w_sum[13:0] << w_shl;
            w_exp  = w_exp - $signed({4'b0000, w_shl});
        end
        w_rup = w_norm[2] & ((|w_norm[1:0]) | w_norm[3]);
        w_rnd = {1'b0, w_norm[12:3]} + {10'd0, w_rup};
        if (w_rnd[10]) begin
            w_exp = w_exp + 8'sd1;
        end
        if (w_big[14:10] == 5'h1F) begin
            w_y = w_big;
        end else if (w_sum == 15'd0) begin
            w_y = 16'h0000;
        end else if (w_exp >= 8'sd31) begin
            w_y = {w_big[15], 5'h1F, 10'd0};
        end else if (w_exp <= 8'sd0) begin
            w_y = {w_big[15], 15'd0};
        end else begin
            w_y = {w_big[15], w_exp[4:0], w_rnd[9:0]};
        end
    end

    pipe_delay #(.W(16), .D(LAT)) u_lat (
        .clk   (clk),
        .reset (1'b0),
        .din   (w_y),
        .dout  (y)
    );

endmodule
`default_nettype wire

// File: rtl/mult_half.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_half                                                    |
// | Description : fp16 multiplier, round-to-nearest-even, LAT-cycle latency.   |
// |               Subnormal inputs/results flush to signed zero; any inf/NaN   |
// |               operand yields signed infinity.                              |
// | Ports       : clk, a[15:0], b[15:0] in; y[15:0] out (a*b, LAT cycles later)|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mult_half #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    logic [21:0]       w_prod;
    logic signed [7:0] w_exp;
    logic [9:0]        w_man;
    logic              w_grd;
    logic              w_stk;
    logic              w_sgn;
    logic              w_rup;
    logic [10:0]       w_rnd;
    logic [15:0]       w_y;

    always_comb begin
        w_sgn  = a[15] ^ b[15];
        w_prod = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        w_exp  = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
        // Product of two 1.x significands lies in [1,4): renormalise on bit 21.
        if (w_prod[21]) begin
            w_man = w_prod[20:11];
            w_grd = w_prod[10];
            w_stk = |w_prod[9:0];
            w_exp = w_exp + 8'sd1;
        end else begin
            w_man = w_prod[19:10];
            w_grd = w_prod[9];
            w_stk = |w_prod[8:0];
        end
        w_rup = w_grd & (w_stk | w_man[0]);
        w_rnd = {1'b0, w_man} + {10'd0, w_rup};
        if (w_rnd[10]) begin
            w_exp = w_exp + 8'sd1;
        end
        if ((a[14:10] == 5'h1F) || (b[14:10] == 5'h1F)) begin
            w_y = {w_sgn, 5'h1F, 10'd0};
        end else if ((a[14:10] == 5'd0) || (b[14:10] == 5'd0)) begin
            w_y = {w_sgn, 15'd0};
        end else if (w_exp >= 8'sd31) begin
            w_y = {w_sgn, 5'h1F, 10'd0};
        end else if (w_exp <= 8'sd0) begin
            w_y = {w_sgn, 15'd0};
        end else begin
            w_y = {w_sgn, w_exp[4:0], w_rnd[9:0]};
        end
    end

    pipe_delay #(.W(16), .D(LAT)) u_lat (
        .clk   (clk),
        .reset (1'b0),
        .din   (w_y),
        .dout  (y)
    );

endmodule
`default_nettype wire

// File: rtl/pipe_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_delay                                                   |
// | Description : D-stage register chain, synchronous active-high reset to 0.  |
// | Ports       : clk, reset, din[W-1:0] in, dout[W-1:0] out (din delayed D)   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pipe_delay #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (D == 0) begin : g_wire
            assign dout = din;
        end else begin : g_chain
            logic [W-1:0] r_stage [D];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < D; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= din;
                    for (int i = 1; i < D; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign dout = r_stage[D-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/matrix_vec_mult_nxn.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matrix_vec_mult_nxn                                          |
// | Description : fp16 out = M * v for an N x N matrix. One row per cycle into |
// |               N multipliers, balanced adder tree, per-row result stream    |
// |               plus assembled output vector. One job per N cycles.          |
// | Ports       : clk, reset (sync, active-high)                               |
// |               in_valid/in_ready, in_mat[N*N*16], in_vec[N*16]  job input   |
// |               res_valid, res_row[2], res_data[16]              row stream  |
// |               out_valid, out_vec[N*16]                         vector      |
// |               busy                                 issue or flight active  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module matrix_vec_mult_nxn
    import matvec_pkg::*;
#(
    parameter int N       = 3,
    parameter int MUL_LAT = 2,
    parameter int ADD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*N*FP16_W-1:0] in_mat,
    input  logic [N*FP16_W-1:0]   in_vec,
    output logic                  res_valid,
    output logic [1:0]            res_row,
    output logic [FP16_W-1:0]     res_data,
    output logic                  out_valid,
    output logic [N*FP16_W-1:0]   out_vec,
    output logic                  busy
);

    localparam int       c_TAG_DLY  = matvec_latency(N, MUL_LAT, ADD_LAT) - 2;
    localparam int       c_TAG_W    = $bits(tag_t);
    localparam logic [1:0] c_LAST_ROW = 2'(N - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_row;
    logic [1:0]            w_row_nxt;
    logic                  w_accept;
    logic [N*N*FP16_W-1:0] r_mat;
    logic [N*FP16_W-1:0]   r_vec;
    logic [FP16_W-1:0]     r_a [N];
    logic [FP16_W-1:0]     r_b [N];
    tag_t                  r_tag;
    tag_t                  w_tag_d;
    logic [7:0]            r_inflight;
    logic [FP16_W-1:0]     w_prod [N];
    logic [FP16_W-1:0]     w_sum;
    logic                  r_res_valid;
    logic [1:0]            r_res_row;
    logic [FP16_W-1:0]     r_res_data;
    logic                  r_out_valid;
    logic [N*FP16_W-1:0]   r_out_vec;

    // Ready on the last issue row lets the next job start with no bubble.
    assign in_ready = (r_state == IDLE) | ((r_state == ISSUE) & (r_row == c_LAST_ROW));
    assign w_accept = in_valid & in_ready & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_row   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ISSUE;
                    w_row_nxt   = 2'd0;
                end
            end
            ISSUE: begin
                if (r_row == c_LAST_ROW) begin
                    w_row_nxt = 2'd0;
                    if (!w_accept) begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_row_nxt = r_row + 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_row_nxt   = 2'd0;
            end
        endcase
    end

    // Operands are captured so the producer may change its inputs freely.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mat <= in_mat;
            r_vec <= in_vec;
        end
    end

    // Issue stage: registered row operands and the matching tag.
    always_ff @(posedge clk) begin
        if (r_state == ISSUE) begin
            for (int c = 0; c < N; c++) begin
                r_a[c] <= r_mat[(int'(r_row) * N + c) * FP16_W +: FP16_W];
                r_b[c] <= r_vec[c * FP16_W +: FP16_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag <= '0;
        end else begin
            r_tag.valid <= (r_state == ISSUE);
            r_tag.row   <= r_row;
            r_tag.last  <= (r_row == c_LAST_ROW);
        end
    end

    pipe_delay #(.W(c_TAG_W), .D(c_TAG_DLY)) u_tag_dly (
        .clk   (clk),
        .reset (reset),
        .din   (r_tag),
        .dout  (w_tag_d)
    );

    // Count of valid tags inside the delay line, for busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 8'd0;
        end else begin
            r_inflight <= r_inflight + 8'(r_tag.valid) - 8'(w_tag_d.valid);
        end
    end

    assign busy = (r_state != IDLE) | r_tag.valid | (r_inflight != 8'd0);

    generate
        for (genvar c = 0; c < N; c++) begin : g_mul
            mult_half #(.LAT(MUL_LAT)) u_mul (
                .clk (clk),
                .a   (r_a[c]),
                .b   (r_b[c]),
                .y   (w_prod[c])
            );
        end

        // Summation order is fixed; results are bit-exact to it.
        if (N == 2) begin : g_tree2
            add_half #(.LAT(ADD_LAT)) u_add_fin (
                .clk (clk), .a(w_prod[0]), .b(w_prod[1]), .y(w_sum)
            );
        end else if (N == 3) begin : g_tree3
            logic [FP16_W-1:0] w_s01;
            logic [FP16_W-1:0] w_p2_d;
            add_half #(.LAT(ADD_LAT)) u_add01 (
                .clk (clk), .a(w_prod[0]), .b(w_prod[1]), .y(w_s01)
            );
            // Odd lane waits one adder stage to meet (p0+p1).
            pipe_delay #(.W(FP16_W), .D(ADD_LAT)) u_p2_dly (
                .clk (clk), .reset(reset), .din(w_prod[2]), .dout(w_p2_d)
            );
            add_half #(.LAT(ADD_LAT)) u_add_fin (
                .clk (clk), .a(w_s01), .b(w_p2_d), .y(w_sum)
            );
        end else begin : g_tree4
            logic [FP16_W-1:0] w_s01;
            logic [FP16_W-1:0] w_s23;
            add_half #(.LAT(ADD_LAT)) u_add01 (
                .clk (clk), .a(w_prod[0]), .b(w_prod[1]), .y(w_s01)
            );
            add_half #(.LAT(ADD_LAT)) u_add23 (
                .clk (clk), .a(w_prod[2]), .b(w_prod[3]), .y(w_s23)
            );
            add_half #(.LAT(ADD_LAT)) u_add_fin (
                .clk (clk), .a(w_s01), .b(w_s23), .y(w_sum)
            );
        end
    endgenerate

    // Output stage: row stream and assembled vector update in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_row   <= 2'd0;
            r_res_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
        end else begin
            r_res_valid <= w_tag_d.valid;
            r_out_valid <= w_tag_d.valid & w_tag_d.last;
            if (w_tag_d.valid) begin
                r_res_row  <= w_tag_d.row;
                r_res_data <= w_sum;
                r_out_vec[int'(w_tag_d.row) * FP16_W +: FP16_W] <= w_sum;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_row   = r_res_row;
    assign res_data  = r_res_data;
    assign out_valid = r_out_valid;
    assign out_vec   = r_out_vec;

endmodule
`default_nettype wire

// File: tb/tb_matrix_vec_mult_nxn.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_matrix_vec_mult_nxn                                       |
// | Description : Directed self-checking bench for matrix_vec_mult_nxn with    |
// |               N=3, N=2 and N=4 instances sharing clock and reset.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_matrix_vec_mult_nxn;

    localparam logic [143:0] ID3  = {16'h3C00, 48'h0, 16'h3C00, 48'h0, 16'h3C00};
    localparam logic [143:0] ID3X2 = {16'h4000, 48'h0, 16'h4000, 48'h0, 16'h4000};
    localparam logic [143:0] ALL2 = {9{16'h4000}};
    localparam logic [47:0]  V123 = {16'h4200, 16'h4000, 16'h3C00};
    localparam logic [47:0]  V321 = {16'h3C00, 16'h4000, 16'h4200};
    localparam logic [47:0]  V111 = {3{16'h3C00}};

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic         in_valid3 = 1'b0, in_ready3;
    logic [143:0] mat3 = '0;
    logic [47:0]  vec3 = '0;
    logic         res_valid3, out_valid3, busy3;
    logic [1:0]   res_row3;
    logic [15:0]  res_data3;
    logic [47:0]  out_vec3;

    logic         in_valid2 = 1'b0, in_ready2;
    logic [63:0]  mat2 = '0;
    logic [31:0]  vec2 = '0;
    logic         res_valid2, out_valid2, busy2;
    logic [1:0]   res_row2;
    logic [15:0]  res_data2;
    logic [31:0]  out_vec2;

    logic         in_valid4 = 1'b0, in_ready4;
    logic [255:0] mat4 = '0;
    logic [63:0]  vec4 = '0;
    logic         res_valid4, out_valid4, busy4;
    logic [1:0]   res_row4;
    logic [15:0]  res_data4;
    logic [63:0]  out_vec4;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int idx;

    logic [15:0] e3 [9] = '{16'h3C00, 16'h4000, 16'h4200,
                            16'h4600, 16'h4600, 16'h4600,
                            16'h4000, 16'h4400, 16'h4600};
    logic [15:0] e_mid [6] = '{16'h3C00, 16'h4000, 16'h4200,
                               16'h4600, 16'h4600, 16'h4600};
    logic [15:0] fpi [16] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                              16'h4500, 16'h4600, 16'h4700, 16'h4800,
                              16'h4880, 16'h4900, 16'h4980, 16'h4A00,
                              16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};
    logic [15:0] e4 [4] = '{16'h4900, 16'h4E80, 16'h5140, 16'h5340};
    logic [15:0] e2 [2] = '{16'h4200, 16'h4700};

    always #5 clk = ~clk;

    matrix_vec_mult_nxn #(.N(3), .MUL_LAT(2), .ADD_LAT(2)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_mat(mat3), .in_vec(vec3), .res_valid(res_valid3), .res_row(res_row3),
        .res_data(res_data3), .out_valid(out_valid3), .out_vec(out_vec3), .busy(busy3)
    );

    matrix_vec_mult_nxn #(.N(2), .MUL_LAT(2), .ADD_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_mat(mat2), .in_vec(vec2), .res_valid(res_valid2), .res_row(res_row2),
        .res_data(res_data2), .out_valid(out_valid2), .out_vec(out_vec2), .busy(busy2)
    );

    matrix_vec_mult_nxn #(.N(4), .MUL_LAT(2), .ADD_LAT(2)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_mat(mat4), .in_vec(vec4), .res_valid(res_valid4), .res_row(res_row4),
        .res_data(res_data4), .out_valid(out_valid4), .out_vec(out_vec4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single N=3 job: results at accept+8..+10, out_valid with the last row.
    task automatic run3(input string tag, input logic [143:0] m,
                        input logic [47:0] v, input logic [47:0] ev);
        mat3 = m;
        vec3 = v;
        in_valid3 = 1'b1;
        chk({tag, "_ready"}, 64'(in_ready3), 64'(1));
        tick(1);
        in_valid3 = 1'b0;
        mat3 = '0;
        vec3 = '0;
        chk({tag, "_busy"}, 64'(busy3), 64'(1));
        tick(7);
        chk({tag, "_early"}, 64'(res_valid3), 64'(0));
        for (int r = 0; r < 3; r++) begin
            tick(1);
            chk({tag, "_valid"}, 64'(res_valid3), 64'(1));
            chk({tag, "_row"}, 64'(res_row3), 64'(r));
            chk({tag, "_data"}, 64'(res_data3), 64'(ev[r*16 +: 16]));
            chk({tag, "_outv"}, 64'(out_valid3), 64'(r == 2));
        end
        chk({tag, "_vec"}, 64'(out_vec3), 64'(ev));
        tick(1);
        chk({tag, "_after_valid"}, 64'({res_valid3, out_valid3}), 64'(0));
        tick(2);
        chk({tag, "_idle_busy"}, 64'(busy3), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst_res_valid", 64'(res_valid3), 64'(0));
        chk("rst_res_row", 64'(res_row3), 64'(0));
        chk("rst_res_data", 64'(res_data3), 64'(0));
        chk("rst_out_valid", 64'(out_valid3), 64'(0));
        chk("rst_out_vec", 64'(out_vec3), 64'(0));
        chk("rst_busy", 64'(busy3), 64'(0));
        reset = 1'b0;
        tick(1);

        // Identity matrix, then all-2.0 matrix
        run3("ident", ID3, V123, V123);
        run3("all2", ALL2, V111, {3{16'h4600}});

        // Three jobs with in_valid held continuously
        mat3 = ID3;
        vec3 = V123;
        in_valid3 = 1'b1;
        tick(1);
        mat3 = ALL2;
        vec3 = V111;
        chk("b2b_ready_k0", 64'(in_ready3), 64'(0));
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            if (k == 3) begin
                mat3 = ID3X2;
                vec3 = V123;
            end
            if (k == 6) in_valid3 = 1'b0;
            if (k <= 5) chk("b2b_ready", 64'(in_ready3), 64'(k % 3 == 2));
            if (k >= 8 && k <= 16) begin
                idx = k - 8;
                chk("b2b_valid", 64'(res_valid3), 64'(1));
                chk("b2b_row", 64'(res_row3), 64'(idx % 3));
                chk("b2b_data", 64'(res_data3), 64'(e3[idx]));
                chk("b2b_outv", 64'(out_valid3), 64'(idx % 3 == 2));
                if (idx % 3 == 2)
                    chk("b2b_vec", 64'(out_vec3), 64'({e3[idx], e3[idx-1], e3[idx-2]}));
            end else if (k == 17) begin
                chk("b2b_end", 64'(res_valid3), 64'(0));
            end
        end
        tick(2);

        // in_valid raised while row 1 is issuing
        mat3 = ID3;
        vec3 = V123;
        in_valid3 = 1'b1;
        tick(1);
        in_valid3 = 1'b0;
        tick(1);
        mat3 = ALL2;
        vec3 = V111;
        in_valid3 = 1'b1;
        chk("mid_ready_row1", 64'(in_ready3), 64'(0));
        tick(1);
        chk("mid_ready_row2", 64'(in_ready3), 64'(1));
        tick(1);
        in_valid3 = 1'b0;
        chk("mid_busy", 64'(busy3), 64'(1));
        tick(4);
        for (int k = 8; k <= 14; k++) begin
            tick(1);
            idx = k - 8;
            if (idx < 6) begin
                chk("mid_valid", 64'(res_valid3), 64'(1));
                chk("mid_row", 64'(res_row3), 64'(idx % 3));
                chk("mid_data", 64'(res_data3), 64'(e_mid[idx]));
            end else begin
                chk("mid_end", 64'(res_valid3), 64'(0));
            end
        end
        tick(2);

        // Reset mid-flight, with a coincident accept that must be ignored
        mat3 = ID3;
        vec3 = V123;
        in_valid3 = 1'b1;
        tick(1);
        in_valid3 = 1'b0;
        tick(4);
        reset = 1'b1;
        mat3 = ALL2;
        vec3 = V111;
        in_valid3 = 1'b1;
        tick(1);
        reset = 1'b0;
        in_valid3 = 1'b0;
        chk("mrst_res_valid", 64'(res_valid3), 64'(0));
        chk("mrst_out_valid", 64'(out_valid3), 64'(0));
        chk("mrst_res_row", 64'(res_row3), 64'(0));
        chk("mrst_res_data", 64'(res_data3), 64'(0));
        chk("mrst_out_vec", 64'(out_vec3), 64'(0));
        chk("mrst_busy", 64'(busy3), 64'(0));
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("mrst_quiet", 64'({res_valid3, out_valid3}), 64'(0));
        end
        chk("mrst_vec_held", 64'(out_vec3), 64'(0));
        run3("post_rst", ID3, V321, V321);

        // N=2 and N=4 instances run concurrently
        mat2 = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
        vec2 = {2{16'h3C00}};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mat4[(r*4+c)*16 +: 16] = fpi[r*4+c];
        vec4 = {4{16'h3C00}};
        in_valid2 = 1'b1;
        in_valid4 = 1'b1;
        tick(1);
        in_valid2 = 1'b0;
        in_valid4 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            chk("n2_valid", 64'(res_valid2), 64'(k == 6 || k == 7));
            chk("n2_outv", 64'(out_valid2), 64'(k == 7));
            if (k == 6 || k == 7) begin
                chk("n2_row", 64'(res_row2), 64'(k - 6));
                chk("n2_data", 64'(res_data2), 64'(e2[k-6]));
            end
            if (k == 7) chk("n2_vec", 64'(out_vec2), 64'({e2[1], e2[0]}));
            chk("n4_valid", 64'(res_valid4), 64'(k >= 8 && k <= 11));
            chk("n4_outv", 64'(out_valid4), 64'(k == 11));
            if (k >= 8 && k <= 11) begin
                chk("n4_row", 64'(res_row4), 64'(k - 8));
                chk("n4_data", 64'(res_data4), 64'(e4[k-8]));
            end
            if (k == 11) chk("n4_vec", 64'(out_vec4), 64'({e4[3], e4[2], e4[1], e4[0]}));
        end
        chk("n2_idle_busy", 64'(busy2), 64'(0));
        chk("n4_idle_busy", 64'(busy4), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_vec_mult_nxn.md
Name: matrix_vec_mult_nxn

Overview:
- Parametrised fp16 matrix-vector multiplier: computes out = M * v for an N x N matrix and an N-vector.
- Issues one matrix row per cycle into N parallel mult_half units, followed by a balanced add_half reduction tree.
- Accepts one job per N cycles with a valid/ready input handshake; back-to-back jobs are fully pipelined.
- Delivers a per-row result stream plus an assembled output vector. Sits in the transform stage ahead of the rasteriser.

Parameters:
- N, 3, matrix dimension; legal range 2..4.
- MUL_LAT, 2, mult_half latency in cycles; must match the IP configuration.
- ADD_LAT, 2, add_half latency in cycles; must match the IP configuration.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  job offered.
- in_ready  out  1  job can be accepted this cycle.
- in_mat  in  N*N*16  row-major; element (r,c) is at bits [(r*N+c)*16 +: 16].
- in_vec  in  N*16  element c is at bits [c*16 +: 16].
- res_valid  out  1  one row result is valid this cycle.
- res_row  out  2  row index of res_data.
- res_data  out  16  fp16 dot product of row res_row with the vector.
- out_valid  out  1  one-cycle pulse: the full result vector is complete.
- out_vec  out  N*16  assembled result; held until the next completion.
- busy  out  1  a job is in issue or in flight.

Behaviour:
- Reset (clk, reset: synchronous, active-high): all outputs are 0. Row counter cleared, issue FSM to IDLE, tag pipeline cleared.
- Any in-flight results are discarded on reset and never emerge. Datapath IP contents are don't-care because the valid tags gate everything.
- Handshake:
  - in_ready = (state==IDLE) | (state==ISSUE & row==N-1).
  - A job is accepted when in_valid & in_ready at a posedge.
  - in_mat and in_vec are captured into operand registers at acceptance. Inputs may change freely afterwards.
- FSM:
  - IDLE -> ISSUE on accept, with row=0.
  - In ISSUE, row increments each cycle.
  - At row==N-1: if a new job is accepted, stay in ISSUE with row=0 (no bubble); otherwise go to IDLE.
- Issue: in ISSUE, row r of the captured matrix drives multiplier c as a=M[r][c], b=v[c], for c=0..N-1.
- Reduction tree:
  - TREE_DEPTH = ceil(log2 N), giving 1 for N=2 and 2 for N=3 or 4.
  - Fixed summation order: N=2: p0+p1. N=3: (p0+p1)+p2, with p2 delayed ADD_LAT cycles through pipe_delay. N=4: (p0+p1)+(p2+p3).
  - Results must be bit-exact to this order.
- Tag pipeline: {valid, row, last} enters alongside the operands and is delayed by MUL_LAT + ADD_LAT*TREE_DEPTH. Its output is registered together with the sum.
- Latency:
  - For a job accepted at edge t, row r appears at edge t + 2 + r + MUL_LAT + ADD_LAT*TREE_DEPTH on res_valid/res_row/res_data.
  - Defaults give row 0 at t+8 and row 2 at t+10.
- Assembly:
  - Each res_valid writes res_data into slot res_row of out_vec.
  - out_valid pulses in the same cycle as the row N-1 result. out_vec includes that row in the same cycle.
- res_valid deasserts between jobs unless jobs are issued back-to-back.
- No output backpressure: the consumer must take results when presented.
- busy = (state!=IDLE) | any valid in the tag pipeline.
- in_valid held while in_ready=0 has no effect, and the job is not lost: it is accepted at the next ready cycle.
- Reset asserted mid-job wins over everything. An accept in the same cycle as reset is ignored.

Decomposition:
- Package matvec_pkg holds:
  - FP16_W=16.
  - Function clog2_tree(N).
  - Function matvec_latency(N, MUL_LAT, ADD_LAT).
  - Issue-FSM state enum {IDLE, ISSUE}.
- One sub-module, pipe_delay #(W, D): a D-stage register chain with synchronous reset to 0. It is used for the odd-lane balancing and for the tag pipeline.
- mult_half and add_half are instantiated directly.

Test Plan:
- N=3, identity matrix (0x3C00 diagonal), v=(1.0,2.0,3.0)=(0x3C00,0x4000,0x4200) -> res rows 0,1,2 at t+8,t+9,t+10; out_valid at t+10 with out_vec=(0x3C00,0x4000,0x4200).
- N=3, all elements of M = 2.0 (0x4000), v=(1.0,1.0,1.0) -> every res_data=0x4600 (6.0); out_valid exactly one cycle.
- N=3, three jobs with in_valid held continuously -> in_ready high at t, t+3, t+6; res_valid high with no gaps for 9 cycles; out_valid at t+10, t+13, t+16.
- N=3, in_valid raised mid-issue (row=1) -> not accepted until row==2; no result corruption; second job's row 0 follows first job's row 2 on the next cycle.
- Reset asserted at t+5 with one job in flight -> no res_valid/out_valid after reset; all outputs 0; busy=0 on the cycle after reset; a new job then completes normally.
- N=2 and N=4 builds with M rows (1,2,3,4)... and v=(1,1,1,1) -> N=4 results (10,26,42,58)=(0x4900,0x4E80,0x5140,0x5340); latency per matvec_latency.
